// File: rtl/vga_tile_pixel_gen.sv
// vga_tile_pixel_gen: picture/coordinate to memory word address, then 3-bit {R,G,B} field select.
// Define VGA_TRANSPARENT_EN to replace 3'b111 fields with BG_COLOR.
module vga_tile_pixel_gen #(
    parameter int PIC_W = 16,
    parameter int PIC_H = 16,
    parameter int PIX_PER_WORD = 3,
    parameter int WORD_W = 9,
    parameter int NUM_PICS = 16,
    parameter int ADDR_W = 12,
    parameter int PIC_BITS = 10,
    parameter int SUB_BITS = 5,
    parameter int MEM_LAT = 1,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PIC_BITS-1:0] pic_num,
    input  logic [SUB_BITS-1:0] x_sub,
    input  logic [SUB_BITS-1:0] y_sub,
    input  logic                act,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [WORD_W-1:0]   mem_data,
    output logic                R,
    output logic                G,
    output logic                B,
    output logic                pix_valid
);
    localparam int WPR = (PIC_W + PIX_PER_WORD - 1) / PIX_PER_WORD;
    localparam int PIC_WORDS = WPR * PIC_H;
    localparam int SW = PIX_PER_WORD > 1 ? $clog2(PIX_PER_WORD) : 1;
`ifdef VGA_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    // Multiply by a constant as a sum of shifted copies; bits past ADDR_W would be truncated anyway.
    function automatic logic [ADDR_W-1:0] cmul(input logic [ADDR_W-1:0] v, input int k);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W && i < 32; i++)
            if (k[i]) acc = acc + (v << i);
        return acc;
    endfunction

    logic              in_range;
    logic [SW-1:0]     slot;
    logic [ADDR_W-1:0] addr_nxt;
    logic [2:0]        field, color;
    logic              v_pipe [0:MEM_LAT];
    logic [SW-1:0]     s_pipe [0:MEM_LAT];

    always_comb begin
        in_range = (32'(pic_num) < NUM_PICS) && (32'(x_sub) < PIC_W) && (32'(y_sub) < PIC_H);
        slot = SW'(32'(x_sub) % PIX_PER_WORD);
        addr_nxt = in_range ? cmul(ADDR_W'(pic_num), PIC_WORDS) + cmul(ADDR_W'(y_sub), WPR)
                              + ADDR_W'(32'(x_sub) / PIX_PER_WORD) : '0;
        // Slot 0 is the most significant field of the word.
        field = 3'(mem_data >> (WORD_W - 3 - 3 * s_pipe[MEM_LAT]));
        color = (TRANSP && field == 3'b111) ? BG_COLOR : field;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            for (int i = 0; i <= MEM_LAT; i++) begin
                v_pipe[i] <= 1'b0;
                s_pipe[i] <= '0;
            end
            {R, G, B} <= 3'b000;
            pix_valid <= 1'b0;
        end else begin
            mem_addr <= addr_nxt;
            v_pipe[0] <= act && in_range;
            s_pipe[0] <= slot;
            for (int i = 1; i <= MEM_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                s_pipe[i] <= s_pipe[i-1];
            end
            {R, G, B} <= v_pipe[MEM_LAT] ? color : 3'b000;
            pix_valid <= v_pipe[MEM_LAT];
        end
    end
endmodule

// File: tb/tb_vga_tile_pixel_gen.sv
// tb_vga_tile_pixel_gen: directed and random samples against an arithmetic pixel model and a synchronous memory.
module tb_vga_tile_pixel_gen;
    typedef struct {
        logic [11:0] addr;
        logic [2:0]  rgb;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pic_num = '0;
    logic [4:0]  x_sub = '0;
    logic [4:0]  y_sub = '0;
    logic        act = 1'b0;
    logic [11:0] mem_addr;
    logic [8:0]  mem_data;
    logic        R, G, B, pix_valid;
    logic [8:0]  mem [0:4095];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    vga_tile_pixel_gen #(.BG_COLOR(3'b001)) dut (
        .clk(clk), .reset(reset), .pic_num(pic_num), .x_sub(x_sub), .y_sub(y_sub),
        .act(act), .mem_addr(mem_addr), .mem_data(mem_data),
        .R(R), .G(G), .B(B), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] pixel(input logic [11:0] a, input int p);
        logic [2:0] f;
        f = 3'((mem[a] >> (3 * (2 - p))) & 9'h7);
`ifdef VGA_TRANSPARENT_EN
        if (f == 3'b111) f = 3'b001;
`endif
        return f;
    endfunction

    task automatic push_black();
        exp_t e;
        e.addr = '0; e.rgb = '0; e.v = 1'b0;
        q.push_back(e);
    endtask

    // One input sample: address checked one edge later, outputs of the sample two back checked too.
    task automatic step(input int p, input int x, input int y, input bit a, input string tag);
        exp_t e, o;
        bit inr;
        pic_num = 10'(p); x_sub = 5'(x); y_sub = 5'(y); act = a;
        inr = p < 16 && x < 16 && y < 16;
        e.addr = inr ? 12'(p * 96 + y * 6 + x / 3) : 12'd0;
        e.v = a && inr;
        e.rgb = e.v ? pixel(e.addr, x % 3) : 3'b000;
        q.push_back(e);
        @(posedge clk); #1;
        chk({tag, "_addr"}, 32'(mem_addr), 32'(e.addr));
        o = q.pop_front();
        chk({tag, "_rgb"}, 32'({R, G, B}), 32'(o.rgb));
        chk({tag, "_valid"}, 32'(pix_valid), 32'(o.v));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 9'($urandom);
        mem[12'h06D] = 9'b000_101_000;
        mem[12'h05F] = 9'b110_000_000;
        mem[12'h0C2] = 9'b111_010_011;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_rgb", 32'({R, G, B}), 0);
        chk("rst_valid", 32'(pix_valid), 0);
        reset = 1'b0;
        push_black(); push_black();
        step(1, 4, 2, 1, "addr6d");
        step(0, 15, 15, 1, "bound5f");
        step(16, 0, 0, 1, "pic16");
        step(0, 16, 0, 1, "x16");
        step(0, 0, 16, 1, "y16");
        step(0, 0, 0, 1, "drain0");
        step(0, 1, 0, 1, "drain1");
        for (int x = 0; x < 16; x++) step(2, x, 0, x != 7, "sweep");
        step(2, 6, 0, 1, "transp");
        step(3, 3, 3, 1, "t1");
        step(3, 4, 3, 1, "t2");
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 18), $urandom_range(0, 18), $urandom_range(0, 18),
                 $urandom_range(0, 4) != 0, "rand");
        reset = 1'b1;
        #1;
        chk("midrst_addr", 32'(mem_addr), 0);
        chk("midrst_rgb", 32'({R, G, B}), 0);
        chk("midrst_valid", 32'(pix_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        push_black(); push_black();
        step(0, 0, 16, 1, "post_oor");
        step(1, 4, 2, 1, "post_first");
        step(0, 0, 0, 0, "post_idle");
        step(0, 0, 0, 0, "post_out");
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 17),
                 $urandom_range(0, 1) != 0, "rand2");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
